// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] ASB_REG  = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;
  localparam logic [1:0] PCS_REG  = 2'b11;

  // States whose exit edge completes an instruction.
  function automatic logic is_retire_state(input state_e s);
    case (s)
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JAL, S_JR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_alu_ctrl.sv
// R-type funct decode to ALU operation, flagging functs the datapath cannot execute.
module alu_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_AND;
    illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with sticky illegal-instruction trap and a
// wrapping retired-instruction counter.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR | effective address for lw/sw
// MEM_RD   | data read at ALUOut
// MEM_WB   | MDR -> rt
// MEM_WR   | B -> memory at ALUOut
// R_EXEC   | A op B per funct
// R_WB     | ALUOut -> rd
// I_EXEC   | A op imm
// I_WB     | ALUOut -> rt
// BRANCH   | compare A/B, conditional PC <= ALUOut
// JUMP     | PC <= jump address
// JAL      | PC <= jump address, r31 <= PC
// JR       | PC <= A
// TRAP     | illegal instruction, parked until reset
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       opr,
  input  logic             zero,
  output logic             pc_load,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             sel_reg,
  output logic             mem_to_reg,
  output logic             jal,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       aluopration,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [2:0]       r_alu_op;
  logic             r_illegal;

  alu_ctrl u_alu_ctrl (
    .funct_i   (opr),
    .alu_op_o  (r_alu_op),
    .illegal_o (r_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retired_d = is_retire_state(state_q) ? retired_q + CNT_W'(1) : retired_q;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_d = (opr == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JAL;
          default:                          state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_R_EXEC:   state_d = r_illegal ? S_TRAP : S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Outputs are held at zero for the whole of any reset cycle so a reset
  // landing mid-instruction never lets a write strobe escape.
  always_comb begin
    pc_load     = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    sel_reg     = 1'b0;
    mem_to_reg  = 1'b0;
    jal         = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = ASB_REG;
    pc_src      = PCS_ALU;
    aluopration = ALU_AND;
    trap        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read    = 1'b1;
          ir_write    = 1'b1;
          alu_src_b   = ASB_FOUR;
          aluopration = ALU_ADD;
          pc_src      = PCS_ALU;
          pc_load     = 1'b1;
        end
        S_DECODE: begin
          alu_src_b   = ASB_IMM2;
          aluopration = ALU_ADD;
        end
        S_MEM_ADDR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = ASB_IMM;
          aluopration = ALU_ADD;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a   = 1'b1;
          alu_src_b   = ASB_REG;
          aluopration = r_alu_op;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
          case (opcode)
            OP_SLTI: aluopration = ALU_SLT;
            OP_ANDI: aluopration = ALU_AND;
            OP_ORI:  aluopration = ALU_OR;
            default: aluopration = ALU_ADD;
          endcase
        end
        S_I_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_src_b   = ASB_REG;
          aluopration = ALU_SUB;
          pc_src      = PCS_OUT;
          pc_load     = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_JUMP: begin
          pc_src  = PCS_JMP;
          pc_load = 1'b1;
        end
        S_JAL: begin
          pc_src    = PCS_JMP;
          pc_load   = 1'b1;
          reg_write = 1'b1;
          sel_reg   = 1'b1;
          jal       = 1'b1;
        end
        S_JR: begin
          pc_src  = PCS_REG;
          pc_load = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b1;
      endcase
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench: each driven cycle pushes its expected control word onto a queue;
// a negedge monitor pops and compares against the DUT outputs.
module tb_mc_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode, opr;
  logic       zero;
  logic       pc_load, iord, mem_read, mem_write, ir_write, reg_write, reg_dst;
  logic       sel_reg, mem_to_reg, jal, alu_src_a, trap;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] aluopration;
  logic [3:0] retired;

  mc_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .opr(opr), .zero(zero),
    .pc_load(pc_load), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .sel_reg(sel_reg),
    .mem_to_reg(mem_to_reg), .jal(jal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .aluopration(aluopration), .trap(trap), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [18:0] ctrl;
    logic [3:0]  ret;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_ret;

  logic [18:0] obs;
  assign obs = {pc_load, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                sel_reg, mem_to_reg, jal, alu_src_a, alu_src_b, pc_src, aluopration, trap};

  function automatic logic [18:0] mk(input logic pl, io, mr, mw, irw, rw, rd, sr, m2r, jl, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] op,
                                     input logic tr);
    return {pl, io, mr, mw, irw, rw, rd, sr, m2r, jl, asa, asb, pcs, op, tr};
  endfunction

  //                    pl io mr mw ir rw rd sr m2 jl sa  asb    pcs    op      trap
  logic [18:0] V_ZERO, V_FETCH, V_DECODE, V_MADDR, V_MRD, V_MWB, V_MWR, V_RWB, V_IWB;
  logic [18:0] V_JUMP, V_JAL, V_JR, V_TRAP;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (obs !== e.ctrl || retired !== e.ret) begin
        errors++;
        $display("FAIL %s: ctrl got %b want %b, retired got %0d want %0d",
                 e.tag, obs, e.ctrl, retired, e.ret);
      end
    end
  end

  task automatic step(input string tag, input logic r, input logic [5:0] opc, fn,
                      input logic z, input logic [18:0] ev, input logic rets);
    rst = r; opcode = opc; opr = fn; zero = z;
    q.push_back('{tag, ev, exp_ret});
    if (r) exp_ret = 4'd0;
    else if (rets) exp_ret = exp_ret + 4'd1;
    @(posedge clk); #1;
  endtask

  task automatic sw_instr(input string tag);
    step({tag, "_fetch"}, 0, 6'b101011, 6'd0, 0, V_FETCH, 0);
    step({tag, "_decode"}, 0, 6'b101011, 6'd0, 0, V_DECODE, 0);
    step({tag, "_maddr"}, 0, 6'b101011, 6'd0, 0, V_MADDR, 0);
    step({tag, "_mwr"}, 0, 6'b101011, 6'd0, 0, V_MWR, 1);
  endtask

  initial begin
    V_ZERO   = '0;
    V_FETCH  = mk(1,0,1,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    V_DECODE = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
    V_MADDR  = mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0);
    V_MRD    = mk(0,1,1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
    V_MWB    = mk(0,0,0,0,0,1,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 0);
    V_MWR    = mk(0,1,0,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
    V_RWB    = mk(0,0,0,0,0,1,1,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
    V_IWB    = mk(0,0,0,0,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
    V_JUMP   = mk(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0);
    V_JAL    = mk(1,0,0,0,0,1,0,1,0,1,0, 2'b00, 2'b10, 3'b000, 0);
    V_JR     = mk(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 3'b000, 0);
    V_TRAP   = mk(0,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1);

    exp_ret = 4'd0;
    rst = 1'b1; opcode = '0; opr = '0; zero = 1'b0;
    @(posedge clk); #1;
    step("rst0", 1, 6'b100011, 6'd0, 0, V_ZERO, 0);
    step("rst1", 1, 6'b100011, 6'd0, 0, V_ZERO, 0);

    // lw: 5 cycles
    step("lw_fetch",  0, 6'b100011, 6'd0, 0, V_FETCH, 0);
    step("lw_decode", 0, 6'b100011, 6'd0, 0, V_DECODE, 0);
    step("lw_maddr",  0, 6'b100011, 6'd0, 0, V_MADDR, 0);
    step("lw_mrd",    0, 6'b100011, 6'd0, 0, V_MRD, 0);
    step("lw_mwb",    0, 6'b100011, 6'd0, 0, V_MWB, 1);

    // R-type add and sub
    step("add_fetch",  0, 6'b000000, 6'b100000, 0, V_FETCH, 0);
    step("add_decode", 0, 6'b000000, 6'b100000, 0, V_DECODE, 0);
    step("add_exec",   0, 6'b000000, 6'b100000, 0, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0), 0);
    step("add_wb",     0, 6'b000000, 6'b100000, 0, V_RWB, 1);
    step("sub_fetch",  0, 6'b000000, 6'b100010, 0, V_FETCH, 0);
    step("sub_decode", 0, 6'b000000, 6'b100010, 0, V_DECODE, 0);
    step("sub_exec",   0, 6'b000000, 6'b100010, 0, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b110,0), 0);
    step("sub_wb",     0, 6'b000000, 6'b100010, 0, V_RWB, 1);

    // I-type ori
    step("ori_fetch",  0, 6'b001101, 6'd0, 0, V_FETCH, 0);
    step("ori_decode", 0, 6'b001101, 6'd0, 0, V_DECODE, 0);
    step("ori_exec",   0, 6'b001101, 6'd0, 0, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b001,0), 0);
    step("ori_wb",     0, 6'b001101, 6'd0, 0, V_IWB, 1);

    // branches: beq taken, beq not taken, bne taken
    step("beq1_fetch",  0, 6'b000100, 6'd0, 1, V_FETCH, 0);
    step("beq1_decode", 0, 6'b000100, 6'd0, 1, V_DECODE, 0);
    step("beq1_br",     0, 6'b000100, 6'd0, 1, mk(1,0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0), 1);
    step("beq0_fetch",  0, 6'b000100, 6'd0, 0, V_FETCH, 0);
    step("beq0_decode", 0, 6'b000100, 6'd0, 0, V_DECODE, 0);
    step("beq0_br",     0, 6'b000100, 6'd0, 0, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0), 1);
    step("bne0_fetch",  0, 6'b000101, 6'd0, 0, V_FETCH, 0);
    step("bne0_decode", 0, 6'b000101, 6'd0, 0, V_DECODE, 0);
    step("bne0_br",     0, 6'b000101, 6'd0, 0, mk(1,0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0), 1);

    // j, jal, jr
    step("j_fetch",    0, 6'b000010, 6'd0, 0, V_FETCH, 0);
    step("j_decode",   0, 6'b000010, 6'd0, 0, V_DECODE, 0);
    step("j_jump",     0, 6'b000010, 6'd0, 0, V_JUMP, 1);
    step("jal_fetch",  0, 6'b000011, 6'd0, 0, V_FETCH, 0);
    step("jal_decode", 0, 6'b000011, 6'd0, 0, V_DECODE, 0);
    step("jal_jal",    0, 6'b000011, 6'd0, 0, V_JAL, 1);
    step("jr_fetch",   0, 6'b000000, 6'b001000, 0, V_FETCH, 0);
    step("jr_decode",  0, 6'b000000, 6'b001000, 0, V_DECODE, 0);
    step("jr_jr",      0, 6'b000000, 6'b001000, 0, V_JR, 1);

    // counter wrap: clear, 15 sw reach 15, 16th wraps to 0
    step("rst_wrap", 1, 6'b101011, 6'd0, 0, V_ZERO, 0);
    for (int i = 0; i < 16; i++) sw_instr($sformatf("sw%0d", i));

    // reset mid-instruction in MEM_ADDR
    step("swr_fetch",  0, 6'b101011, 6'd0, 0, V_FETCH, 0);
    step("swr_decode", 0, 6'b101011, 6'd0, 0, V_DECODE, 0);
    step("swr_rst",    1, 6'b101011, 6'd0, 0, V_ZERO, 0);
    sw_instr("swr_after");

    // illegal opcode
    step("ill_fetch",  0, 6'b111111, 6'd0, 0, V_FETCH, 0);
    step("ill_decode", 0, 6'b111111, 6'd0, 0, V_DECODE, 0);
    for (int i = 0; i < 10; i++) step($sformatf("ill_trap%0d", i), 0, 6'b111111, 6'd0, i[0], V_TRAP, 0);
    step("ill_rst",    1, 6'b111111, 6'd0, 0, V_ZERO, 0);
    step("ill_clear",  0, 6'b000000, 6'b000111, 0, V_FETCH, 0);

    // illegal funct
    step("fn_decode", 0, 6'b000000, 6'b000111, 0, V_DECODE, 0);
    step("fn_exec",   0, 6'b000000, 6'b000111, 0, mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,0), 0);
    for (int i = 0; i < 10; i++) step($sformatf("fn_trap%0d", i), 0, 6'b000000, 6'b000111, 0, V_TRAP, 0);
    step("fn_rst",    1, 6'b000000, 6'b000111, 0, V_ZERO, 0);
    step("fn_clear",  0, 6'b100011, 6'd0, 0, V_FETCH, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
